// File: rtl/ct_width_down_pkg.sv
// Shared helpers for the ct width-conversion blocks: counter sizing and
// elaboration-time legality of the width ratio.
package ct_width_down_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Ratio must be a power of two in 2..16 and divide the input word evenly.
    function automatic bit ratio_ok(input int unsigned ratio, input int unsigned in_width);
        return (ratio >= 2) && (ratio <= 16) && ((ratio & (ratio - 1)) == 0)
            && ((in_width % ratio) == 0);
    endfunction

endpackage

// File: rtl/ct_width_down.sv
// Width down-converter: splits each upstream word into RATIO little-endian
// beats, with short final words on eop and zero-bubble reload.
module ct_width_down
    import ct_width_down_pkg::*;
#(
    parameter  int IN_WIDTH  = 256,
    parameter  int RATIO     = 4,
    localparam int OUT_WIDTH = IN_WIDTH / RATIO,
    localparam int CNT_W     = int'(clog2(RATIO))
) (
    input  logic                 rdclk,
    input  logic                 arst,
    input  logic [IN_WIDTH-1:0]  i_data,
    input  logic                 i_valid,
    input  logic                 i_eop,
    input  logic [CNT_W-1:0]     i_last_beats,
    output logic                 o_ready,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_eop,
    input  logic                 i_ready
);

    if (!ratio_ok(RATIO, IN_WIDTH)) begin : g_bad_ratio
        $error("ct_width_down: RATIO must be a power of two in 2..16 dividing IN_WIDTH");
    end

    localparam logic [CNT_W-1:0] FULL_END = CNT_W'(RATIO - 1);

    logic                busy;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    end_idx;
    logic                held_eop;
    logic [IN_WIDTH-1:0] held;

    logic last_beat;
    logic take;
    logic accept;

    assign last_beat = busy && (cnt == end_idx);
    assign take      = busy && i_ready;
    // Reload is allowed in the same cycle the final beat leaves, so a new
    // word's beat 0 follows the old word's last beat with no gap.
    assign o_ready   = !busy || (take && last_beat);
    assign accept    = i_valid && o_ready;

    always_ff @(posedge rdclk or posedge arst) begin
        if (arst) begin
            busy     <= 1'b0;
            cnt      <= '0;
            end_idx  <= '0;
            held_eop <= 1'b0;
            held     <= '0;
        end else if (accept) begin
            busy     <= 1'b1;
            cnt      <= '0;
            end_idx  <= i_eop ? i_last_beats : FULL_END;
            held_eop <= i_eop;
            held     <= i_data;
        end else if (take) begin
            if (last_beat) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign o_valid = busy;
    assign o_eop   = held_eop && last_beat;

    always_comb begin
        o_data = '0;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (cnt == CNT_W'(k)) begin
                o_data = held[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_ct_width_down.sv
// Scoreboard bench for ct_width_down at IN_WIDTH=256, RATIO=4.
module tb_ct_width_down;

    logic         rdclk = 1'b0;
    logic         arst;
    logic [255:0] i_data;
    logic         i_valid;
    logic         i_eop;
    logic [1:0]   i_last_beats;
    logic         o_ready;
    logic [63:0]  o_data;
    logic         o_valid;
    logic         o_eop;
    logic         i_ready;

    always #5 rdclk = ~rdclk;

    ct_width_down #(.IN_WIDTH(256), .RATIO(4)) dut (
        .rdclk        (rdclk),
        .arst         (arst),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .i_eop        (i_eop),
        .i_last_beats (i_last_beats),
        .o_ready      (o_ready),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_eop        (o_eop),
        .i_ready      (i_ready)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        e;
    } beat_t;

    beat_t sb[$];
    beat_t exp_b;
    int    vectors     = 0;
    int    miscompares = 0;

    function automatic logic [255:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Expected beats for one accepted word.
    function automatic void push_word(input logic [255:0] w, input logic eop, input logic [1:0] lb);
        int    n;
        beat_t b;
        n = eop ? int'(lb) + 1 : 4;
        for (int k = 0; k < n; k++) begin
            b.d = w[k*64 +: 64];
            b.e = eop && (k == n - 1);
            sb.push_back(b);
        end
    endfunction

    task automatic test_reset();
        @(negedge rdclk);
        arst = 1'b1;
        #1;
        vectors++;
        if ({o_valid, o_eop, o_ready} !== 3'b001 || o_data !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b eop=%b ready=%b data=%h, want 0 0 1 0",
                     o_valid, o_eop, o_ready, o_data);
        end
        @(negedge rdclk);
        arst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [255:0] w[2];
        int widx = 0;
        w[0] = rand_word();
        w[1] = rand_word();
        for (int c = 0; c < 10; c++) begin
            @(negedge rdclk);
            i_valid = (widx < 2);
            i_data = w[(widx < 2) ? widx : 1];
            i_eop = 1'b0;
            i_last_beats = 2'd0;
            i_ready = 1'b1;
            #1;
            if (c >= 1 && c <= 8) begin
                vectors++;
                if (o_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bb_nogap: cycle %0d o_valid=%b want 1", c, o_valid);
                end
            end
            if (c >= 1 && c <= 7) begin
                vectors++;
                if (o_ready !== (c == 4)) begin
                    miscompares++;
                    $display("FAIL bb_ready: cycle %0d o_ready=%b want %b", c, o_ready, (c == 4));
                end
            end
            if (c == 9) begin
                vectors++;
                if (o_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bb_idle: o_valid=%b want 0", o_valid);
                end
            end
            if (o_valid && i_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL bb_beat: unexpected beat data=%h eop=%b", o_data, o_eop);
                end else begin
                    exp_b = sb.pop_front();
                    if (o_data !== exp_b.d || o_eop !== exp_b.e) begin
                        miscompares++;
                        $display("FAIL bb_beat: got %h/%b want %h/%b", o_data, o_eop, exp_b.d, exp_b.e);
                    end
                end
            end
            if (i_valid && o_ready) begin
                push_word(i_data, i_eop, i_last_beats);
                widx++;
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL bb_drain: %0d beats missing, want 0", sb.size());
        end
    endtask

    task automatic test_short_eop();
        logic [255:0] w[2];
        int widx = 0;
        w[0] = rand_word();
        w[1] = rand_word();
        for (int c = 0; c < 8; c++) begin
            @(negedge rdclk);
            i_valid = (widx < 2);
            i_data = w[(widx < 2) ? widx : 1];
            i_eop = (widx == 0);
            i_last_beats = (widx == 0) ? 2'd1 : 2'd3;
            i_ready = 1'b1;
            #1;
            if (c == 1) begin
                vectors++;
                if (o_eop !== 1'b0 || o_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL short_beat0: eop=%b ready=%b want 0 0", o_eop, o_ready);
                end
            end
            if (c == 2) begin
                vectors++;
                if (o_eop !== 1'b1 || o_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL short_beat1: eop=%b ready=%b want 1 1", o_eop, o_ready);
                end
            end
            if (c == 3) begin
                vectors++;
                if (o_valid !== 1'b1 || o_data !== w[1][63:0]) begin
                    miscompares++;
                    $display("FAIL short_next: valid=%b data=%h want 1 %h", o_valid, o_data, w[1][63:0]);
                end
            end
            if (o_valid && i_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL short_beat: unexpected beat data=%h eop=%b", o_data, o_eop);
                end else begin
                    exp_b = sb.pop_front();
                    if (o_data !== exp_b.d || o_eop !== exp_b.e) begin
                        miscompares++;
                        $display("FAIL short_beat: got %h/%b want %h/%b", o_data, o_eop, exp_b.d, exp_b.e);
                    end
                end
            end
            if (i_valid && o_ready) begin
                push_word(i_data, i_eop, i_last_beats);
                widx++;
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL short_drain: %0d beats missing, want 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] w[2];
        int widx = 0;
        w[0] = rand_word();
        w[1] = rand_word();
        for (int c = 0; c < 15; c++) begin
            @(negedge rdclk);
            i_valid = (widx < 2);
            i_data = w[(widx < 2) ? widx : 1];
            i_eop = 1'b0;
            i_last_beats = 2'd0;
            i_ready = !(c >= 3 && c <= 7);
            #1;
            if (c >= 3 && c <= 7) begin
                vectors++;
                if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data !== w[0][191:128] || o_eop !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_hold: cycle %0d valid=%b ready=%b eop=%b data=%h want 1 0 0 %h",
                             c, o_valid, o_ready, o_eop, o_data, w[0][191:128]);
                end
            end
            if (c == 14) begin
                vectors++;
                if (o_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_idle: o_valid=%b want 0", o_valid);
                end
            end
            if (o_valid && i_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL bp_beat: unexpected beat data=%h eop=%b", o_data, o_eop);
                end else begin
                    exp_b = sb.pop_front();
                    if (o_data !== exp_b.d || o_eop !== exp_b.e) begin
                        miscompares++;
                        $display("FAIL bp_beat: got %h/%b want %h/%b", o_data, o_eop, exp_b.d, exp_b.e);
                    end
                end
            end
            if (i_valid && o_ready) begin
                push_word(i_data, i_eop, i_last_beats);
                widx++;
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL bp_drain: %0d beats missing, want 0", sb.size());
        end
    endtask

    task automatic test_ignored_field();
        logic [255:0] w;
        int widx = 0;
        w = rand_word();
        for (int c = 0; c < 7; c++) begin
            @(negedge rdclk);
            i_ready = 1'b1;
            if (c == 0) begin
                i_valid = 1'b0;
                i_eop = 1'b1;
                i_last_beats = 2'd0;
                i_data = rand_word();
            end else begin
                i_valid = (widx < 1);
                i_data = w;
                i_eop = 1'b0;
                i_last_beats = 2'd2;
            end
            #1;
            if (c == 1 || c == 6) begin
                vectors++;
                if (o_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ign_idle: cycle %0d o_valid=%b want 0", c, o_valid);
                end
            end
            if (o_valid) begin
                vectors++;
                if (o_eop !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ign_eop: cycle %0d o_eop=%b want 0", c, o_eop);
                end
            end
            if (o_valid && i_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL ign_beat: unexpected beat data=%h eop=%b", o_data, o_eop);
                end else begin
                    exp_b = sb.pop_front();
                    if (o_data !== exp_b.d || o_eop !== exp_b.e) begin
                        miscompares++;
                        $display("FAIL ign_beat: got %h/%b want %h/%b", o_data, o_eop, exp_b.d, exp_b.e);
                    end
                end
            end
            if (i_valid && o_ready) begin
                push_word(i_data, i_eop, i_last_beats);
                widx++;
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL ign_drain: %0d beats missing, want 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] w[2];
        w[0] = rand_word();
        w[1] = rand_word();
        for (int c = 0; c < 10; c++) begin
            @(negedge rdclk);
            arst = (c == 2);
            i_ready = (c != 2);
            i_valid = (c == 0) || (c == 4);
            i_data = (c < 4) ? w[0] : w[1];
            i_eop = 1'b0;
            i_last_beats = 2'd0;
            #1;
            if (c == 2) begin
                vectors++;
                if (o_valid !== 1'b0 || o_eop !== 1'b0 || o_ready !== 1'b1 || o_data !== 64'd0) begin
                    miscompares++;
                    $display("FAIL rstmid_out: valid=%b eop=%b ready=%b data=%h want 0 0 1 0",
                             o_valid, o_eop, o_ready, o_data);
                end
                sb.delete();
            end
            if (c == 3 || c == 4 || c == 9) begin
                vectors++;
                if (o_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rstmid_idle: cycle %0d o_valid=%b want 0", c, o_valid);
                end
            end
            if (c == 5) begin
                vectors++;
                if (o_data !== w[1][63:0]) begin
                    miscompares++;
                    $display("FAIL rstmid_beat0: data=%h want %h", o_data, w[1][63:0]);
                end
            end
            if (!arst && o_valid && i_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rstmid_beat: unexpected beat data=%h eop=%b", o_data, o_eop);
                end else begin
                    exp_b = sb.pop_front();
                    if (o_data !== exp_b.d || o_eop !== exp_b.e) begin
                        miscompares++;
                        $display("FAIL rstmid_beat: got %h/%b want %h/%b", o_data, o_eop, exp_b.d, exp_b.e);
                    end
                end
            end
            if (!arst && i_valid && o_ready) begin
                push_word(i_data, i_eop, i_last_beats);
            end
        end
        arst = 1'b0;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL rstmid_drain: %0d beats missing, want 0", sb.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 1'b1;
        i_data = '0;
        i_valid = 1'b0;
        i_eop = 1'b0;
        i_last_beats = 2'd0;
        i_ready = 1'b1;
        repeat (2) @(negedge rdclk);
        arst = 1'b0;

        test_reset();
        test_back_to_back();
        test_short_eop();
        test_backpressure();
        test_ignored_field();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ct_width_down.md
CT_WIDTH_DOWN -- requirements
Module: ct_width_down

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 256, input word width in bits.
REQ-002 SHALL have parameter RATIO, default 4, input-to-output width ratio; power of two, 2..16.
REQ-003 SHALL have derived localparam OUT_WIDTH = IN_WIDTH/RATIO and CNT_W = clog2(RATIO).
REQ-004 SHALL have port rdclk  in  1  clock; all logic in this domain.
REQ-005 SHALL have port arst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_data  in  IN_WIDTH  word from the upstream clock-crossing FIFO.
REQ-007 SHALL have port i_valid  in  1  upstream word valid.
REQ-008 SHALL have port i_eop  in  1  word is the last of a packet.
REQ-009 SHALL have port i_last_beats  in  CNT_W  (number of valid sub-words - 1) in an eop word; ignored when i_eop=0.
REQ-010 SHALL have port o_ready  out  1  word accept to upstream.
REQ-011 SHALL have port o_data  out  OUT_WIDTH  output beat.
REQ-012 SHALL have port o_valid  out  1  output beat valid.
REQ-013 SHALL have port o_eop  out  1  beat is the last of a packet.
REQ-014 SHALL have port i_ready  in  1  downstream beat accept.

Function
REQ-015 SHALL accept a word when i_valid && o_ready; capture i_data, i_eop, and end index (i_eop ? i_last_beats : RATIO-1) into a holding register; set busy.
REQ-016 SHALL drive o_ready = !busy || (o_valid && i_ready && cnt == end index), combinationally; zero-bubble reload on the last beat.
REQ-017 SHALL emit sub-words little-endian: beat k = held[k*OUT_WIDTH +: OUT_WIDTH], k = 0 first.
REQ-018 SHALL make beat 0 valid in the cycle after acceptance (latency 1); o_valid = busy.
REQ-019 SHALL advance cnt on o_valid && i_ready; clear cnt to 0 on the last beat or on reload.
REQ-020 SHALL drive o_eop = held_eop && (cnt == end index); o_eop is never 1 on non-final beats.
REQ-021 SHALL hold o_data, o_eop, o_valid stable while o_valid && !i_ready.
REQ-022 SHALL clear busy after the last beat is taken if no word is accepted in the same cycle.
REQ-023 SHALL sustain full throughput: RATIO beats per non-eop word, no idle cycles between consecutive words when i_valid and i_ready stay high.
REQ-024 SHALL emit exactly i_last_beats+1 beats for an eop word; i_last_beats = RATIO-1 gives a full word.
REQ-025 SHALL ignore i_eop and i_last_beats when i_valid=0.

Reset
REQ-026 SHALL on arst clear busy, cnt, held_eop, end index and holding data to 0 asynchronously.
REQ-027 SHALL give reset output values o_valid=0, o_eop=0, o_data=0, o_ready=1.
REQ-028 SHALL drop any partially emitted word on arst mid-operation; no beat follows until a new acceptance after arst deasserts.

Structure
REQ-029 SHALL be one module with no sub-module; control is a busy flag plus CNT_W-bit beat counter.
REQ-030 SHALL place clog2 and the RATIO legality check in the shared ct package; no typedefs needed.
REQ-031 SHALL implement o_data as a registered-holder mux indexed by cnt; no combinational path from i_data to o_data.

Verification (IN_WIDTH=256, RATIO=4)
REQ-032 SHALL cover reset: arst pulse -> o_valid=0, o_eop=0, o_data=0, o_ready=1 in the same cycle.
REQ-033 SHALL cover back-to-back: words A, B with i_eop=0, i_ready=1 -> 8 consecutive beats A0..A3 B0..B3, o_ready high only on A3 cycle, no gaps.
REQ-034 SHALL cover short eop: i_eop=1, i_last_beats=1 -> 2 beats, o_eop=1 on beat 1 only, next word's beat 0 in the following cycle.
REQ-035 SHALL cover backpressure: i_ready=0 for 5 cycles at beat 2 -> o_data=word[191:128] and o_valid=1 held all 5 cycles, o_ready=0.
REQ-036 SHALL cover ignored field: i_eop=0, i_last_beats=2 -> 4 beats, o_eop=0 throughout.
REQ-037 SHALL cover reset mid-word: arst during beat 1 -> o_valid=0; after release, next accepted word starts at beat 0.
